// File: rtl/fpga_puf_reader.sv
// fpga_puf_reader: repeats arbiter PUF evaluations, majority-votes each bit and
// reports a per-bit stability mask through a valid/ready port.
module fpga_puf_reader #(
  parameter int PUF_WIDTH     = 96,
  parameter int NUM_EVAL      = 15,
  parameter int CAPTURE_DELAY = 2,
  parameter int TIMEOUT       = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 puf_trig,
  input  logic [2:0]           puf_state,
  input  logic [PUF_WIDTH-1:0] puf_out,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [PUF_WIDTH-1:0] resp_data,
  output logic [PUF_WIDTH-1:0] resp_stable,
  output logic                 resp_error
);
  localparam int CW = $clog2(NUM_EVAL + 1);
  localparam logic [CW-1:0] NE = CW'(NUM_EVAL);
  localparam logic [CW-1:0] HALF = CW'(NUM_EVAL / 2);
  localparam logic [15:0] TMO = 16'(TIMEOUT);
  typedef enum logic [2:0] {IDLE, WAIT_IDLE, TRIG, WAIT_SAMPLE, DELAY, CAPTURE, VOTE, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] ones_cnt [PUF_WIDTH];
  logic [CW-1:0] eval_cnt;
  logic [15:0] tmo_cnt;
  logic [3:0] dly_cnt;
  logic tmo_hit, err;
  assign tmo_hit = tmo_cnt >= TMO;
  always_comb begin
    next = state;
    err = 1'b0;
    case (state)
      IDLE: next = start ? WAIT_IDLE : IDLE;
      WAIT_IDLE: begin
        next = puf_state == 3'b001 ? TRIG : tmo_hit ? DONE : WAIT_IDLE;
        err = puf_state != 3'b001 && tmo_hit;
      end
      TRIG: next = WAIT_SAMPLE;
      // A one-cycle capture delay needs no DELAY state at all.
      WAIT_SAMPLE: begin
        next = puf_state == 3'b100 ? (CAPTURE_DELAY == 1 ? CAPTURE : DELAY) : tmo_hit ? DONE : WAIT_SAMPLE;
        err = puf_state != 3'b100 && tmo_hit;
      end
      DELAY: next = dly_cnt <= 4'd1 ? CAPTURE : DELAY;
      CAPTURE: next = eval_cnt == NE - CW'(1) ? VOTE : WAIT_IDLE;
      VOTE: next = DONE;
      DONE: next = resp_ready ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      busy <= 1'b0;
      puf_trig <= 1'b0;
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_stable <= '0;
      resp_error <= 1'b0;
      tmo_cnt <= '0;
      dly_cnt <= '0;
      eval_cnt <= '0;
      for (int i = 0; i < PUF_WIDTH; i++) ones_cnt[i] <= '0;
    end else begin
      state <= next;
      busy <= next != IDLE;
      puf_trig <= next == TRIG;
      resp_valid <= next == DONE;
      tmo_cnt <= (state == IDLE || state == TRIG || state == CAPTURE) ? '0 : tmo_cnt != '1 ? tmo_cnt + 16'd1 : tmo_cnt;
      dly_cnt <= state == WAIT_SAMPLE ? 4'(CAPTURE_DELAY - 1) : state == DELAY ? dly_cnt - 4'd1 : dly_cnt;
      if (state == IDLE) begin
        eval_cnt <= '0;
        for (int i = 0; i < PUF_WIDTH; i++) ones_cnt[i] <= '0;
      end else if (state == CAPTURE) begin
        eval_cnt <= eval_cnt + CW'(1);
        for (int i = 0; i < PUF_WIDTH; i++) ones_cnt[i] <= ones_cnt[i] + CW'(puf_out[i]);
      end
      if (state == VOTE) begin
        for (int i = 0; i < PUF_WIDTH; i++) begin
          resp_data[i] <= ones_cnt[i] > HALF;
          resp_stable[i] <= ones_cnt[i] == '0 || ones_cnt[i] == NE;
        end
        resp_error <= 1'b0;
      end
      if (err) begin
        resp_data <= '0;
        resp_stable <= '0;
        resp_error <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fpga_puf_reader.sv
// tb_fpga_puf_reader: directed vectors against a behavioural PUF engine that only
// presents the real response on the exact capture cycle.
module tb_fpga_puf_reader;
  localparam logic [95:0] ONES = {96{1'b1}};
  localparam logic [95:0] A5 = {12{8'hA5}};
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic resp_ready = 1'b0;
  logic busy, puf_trig, resp_valid, resp_error;
  logic [2:0] puf_state = 3'b001;
  logic [95:0] puf_out = '0;
  logic [95:0] resp_data, resp_stable;
  int ncmp = 0;
  int nerr = 0;
  int mode = 0;
  int run = 4;
  int slen = 1;
  logic [95:0] base = '0;
  int ecyc = 1000000;
  int trig_cnt = 0;
  int long_cnt = 0;
  int retrig_cnt = 0;
  logic prev_trig = 1'b0;
  logic stuck = 1'b0;
  logic [95:0] pat;
  typedef struct {
    int mode;
    logic [95:0] base;
    int run;
    int slen;
    logic [95:0] d;
    logic [95:0] s;
    logic e;
    int trigs;
  } vec_t;
  vec_t v [6];
  fpga_puf_reader dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .puf_trig(puf_trig),
    .puf_state(puf_state), .puf_out(puf_out), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_stable(resp_stable), .resp_error(resp_error)
  );
  always #5 clk = ~clk;
  // Engine: 010 for one cycle, 011 for run cycles, 100 for slen cycles, then idle.
  always @(negedge clk) begin
    if (mode != 2) stuck = 1'b0;
    if (puf_trig) begin
      if (prev_trig) long_cnt++;
      else begin
        if (puf_state != 3'b001) retrig_cnt++;
        ecyc = 0;
        trig_cnt++;
        stuck = mode == 2;
      end
    end else if (ecyc < 1000000) ecyc++;
    prev_trig = puf_trig;
    pat = base;
    if (mode == 1) begin
      pat[0] = trig_cnt - 1 < 8;
      pat[1] = trig_cnt - 1 < 7;
    end
    puf_state = ecyc == 0 ? 3'b010 : (ecyc <= run || stuck) ? 3'b011 : ecyc <= run + slen ? 3'b100 : 3'b001;
    puf_out = ecyc == run + 3 ? pat : ~pat;
  end
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!resp_valid && cyc < 20000) begin
      tick;
      cyc++;
    end
    chk("valid_seen", 96'(resp_valid), 96'(1));
  endtask
  task automatic wait_trig(input int n);
    int c = 0;
    while (trig_cnt < n && c < 5000) begin
      tick;
      c++;
    end
    chk("trig_reached", 96'(trig_cnt >= n), 96'(1));
  endtask
  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task automatic ack;
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk("ack_valid", 96'(resp_valid), 96'(0));
    chk("ack_busy", 96'(busy), 96'(0));
  endtask
  task automatic chk_result(input logic [95:0] d, input logic [95:0] s, input logic e, input int trigs);
    chk("data", resp_data, d);
    chk("stable", resp_stable, s);
    chk("error", 96'(resp_error), 96'(e));
    chk("trigs", 96'(trig_cnt), 96'(trigs));
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, 96'(busy), 96'(0));
    chk({nm, "_trig"}, 96'(puf_trig), 96'(0));
    chk({nm, "_valid"}, 96'(resp_valid), 96'(0));
    chk({nm, "_data"}, resp_data, '0);
    chk({nm, "_stable"}, resp_stable, '0);
    chk({nm, "_error"}, 96'(resp_error), 96'(0));
  endtask
  initial begin
    int cyc;
    int bad;
    v[0] = '{0, A5, 4, 1, A5, ONES, 1'b0, 15};
    v[1] = '{1, A5, 7, 2, A5, ~96'h3, 1'b0, 15};
    v[2] = '{0, 96'h0, 1, 5, 96'h0, ONES, 1'b0, 15};
    v[3] = '{1, 96'h0123_4567_89AB_CDEF_FEDC_BA98, 3, 3, 96'h0123_4567_89AB_CDEF_FEDC_BA99, ~96'h3, 1'b0, 15};
    v[4] = '{1, ONES, 2, 1, ~96'h2, ~96'h3, 1'b0, 15};
    v[5] = '{2, A5, 4, 1, 96'h0, 96'h0, 1'b1, 1};
    repeat (3) tick;
    chk_zero("reset");
    reset = 1'b1;
    tick;
    for (int k = 0; k < 6; k++) begin
      mode = v[k].mode;
      base = v[k].base;
      run = v[k].run;
      slen = v[k].slen;
      trig_cnt = 0;
      pulse_start;
      wait_valid(cyc);
      chk_result(v[k].d, v[k].s, v[k].e, v[k].trigs);
      if (v[k].mode == 2) chk("timeout_latency", 96'(cyc >= 255 && cyc <= 262), 96'(1));
      ack;
    end
    mode = 0;
    repeat (5) tick;
    // Response held in DONE while the consumer stalls.
    base = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;
    run = 5;
    slen = 2;
    trig_cnt = 0;
    pulse_start;
    wait_valid(cyc);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      if (!resp_valid || !busy || puf_trig || resp_data !== base || resp_stable !== ONES || resp_error) bad++;
      tick;
    end
    chk("hold_stable", 96'(bad), 96'(0));
    chk("hold_trigs", 96'(trig_cnt), 96'(15));
    ack;
    // Extra start while busy is dropped; long 100 phase captured once.
    mode = 1;
    base = 96'h5555_AAAA_5555_AAAA_5555_AAAC;
    slen = 3;
    trig_cnt = 0;
    pulse_start;
    wait_trig(3);
    pulse_start;
    wait_valid(cyc);
    chk_result(96'h5555_AAAA_5555_AAAA_5555_AAAD, ~96'h3, 1'b0, 15);
    ack;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (busy || puf_trig) bad++;
      tick;
    end
    chk("start_not_queued", 96'(bad), 96'(0));
    chk("start_trigs", 96'(trig_cnt), 96'(15));
    // Reset during the 7th evaluation aborts cleanly.
    mode = 0;
    base = ONES;
    run = 6;
    slen = 1;
    trig_cnt = 0;
    pulse_start;
    wait_trig(7);
    tick;
    tick;
    reset = 1'b0;
    tick;
    chk_zero("abort");
    reset = 1'b1;
    repeat (40) tick;
    chk("abort_no_trig", 96'(trig_cnt), 96'(7));
    chk("abort_idle", 96'(busy), 96'(0));
    mode = 1;
    base = 96'h0;
    trig_cnt = 0;
    pulse_start;
    wait_valid(cyc);
    chk_result(96'h1, ~96'h3, 1'b0, 15);
    ack;
    chk("single_cycle_trig", 96'(long_cnt), 96'(0));
    chk("no_retrigger_busy", 96'(retrig_cnt), 96'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/fpga_puf_reader.md
# fpga_puf_reader

Challenge-side controller for the 96-bit arbiter PUF engine. It drives the engine's trigger and tracks its state code. It captures the PUF response after each evaluation and accumulates per-bit "one" counts over NUM_EVAL repeated evaluations. It then returns a majority-voted response and a per-bit stability mask through a valid/ready port. It sits between the PUF engine and the key-generation / host-register logic.

## Interface
Parameters:
- PUF_WIDTH, 96, response width; must equal the engine output width.
- NUM_EVAL, 15, evaluations per request; odd, 1..255.
- CAPTURE_DELAY, 2, cycles from observing state code 3'b100 to capturing puf_out; 1..15.
- TIMEOUT, 255, maximum cycles to wait for any expected engine state code; 1..65535.

Ports:
- clk, in, 1, clock.
- reset, in, 1, reset, synchronous, active-low.
- start, in, 1, single-cycle request; sampled only in IDLE.
- busy, out, 1, high in every state except IDLE.
- puf_trig, out, 1, registered trigger to the engine.
- puf_state, in, 3, engine state code: 001 idle, 010 start, 011 run, 100 sample.
- puf_out, in, PUF_WIDTH, engine response.
- resp_valid, out, 1, response available.
- resp_ready, in, 1, consumer accepts the response.
- resp_data, out, PUF_WIDTH, majority-voted response.
- resp_stable, out, PUF_WIDTH, bit i = 1 if all NUM_EVAL samples of bit i agreed.
- resp_error, out, 1, engine timeout occurred; valid only with resp_valid.

## Operation
- Per-bit counters ones_cnt[i] are $clog2(NUM_EVAL+1) bits wide. eval_cnt has the same width.
- Counters never overflow, because each counter increments at most NUM_EVAL times.
- FSM states: IDLE, WAIT_IDLE, TRIG, WAIT_SAMPLE, DELAY, CAPTURE, VOTE, DONE.
- IDLE:
  - start=1 → WAIT_IDLE.
  - Clear ones_cnt, eval_cnt and the timeout counter.
- WAIT_IDLE: waits for puf_state==3'b001.
  - On that code → TRIG.
  - If TIMEOUT cycles elapse first → DONE with error.
- TRIG:
  - puf_trig=1 for exactly this one cycle.
  - Reset the timeout counter.
  - → WAIT_SAMPLE.
- WAIT_SAMPLE: waits for puf_state==3'b100.
  - On that code → DELAY, loaded with CAPTURE_DELAY-1.
  - On timeout → DONE with error.
- DELAY: counts down; at 0 → CAPTURE.
- CAPTURE:
  - For every bit i: ones_cnt[i] += puf_out[i].
  - eval_cnt += 1.
  - If the new eval_cnt == NUM_EVAL → VOTE; else → WAIT_IDLE.
- VOTE (one cycle) registers:
  - resp_data[i] = (ones_cnt[i] > NUM_EVAL/2).
  - resp_stable[i] = (ones_cnt[i]==0) || (ones_cnt[i]==NUM_EVAL).
  - resp_error = 0.
  - → DONE.
- DONE:
  - resp_valid=1.
  - resp_data, resp_stable and resp_error are held stable while resp_valid && !resp_ready.
  - On resp_valid && resp_ready → IDLE.
- Error path:
  - resp_data = 0, resp_stable = 0, resp_error = 1.
  - Partial counts are discarded.
- The block never retriggers while the engine is not idle. This gives a guaranteed single evaluation per trigger.

## Timing
- Reset values (reset==0 at a clk edge): state IDLE, busy 0, puf_trig 0, resp_valid 0, resp_data 0, resp_stable 0, resp_error 0, all counters 0.
- Reset mid-operation aborts immediately:
  - No further puf_trig is issued.
  - Any pending response is dropped.
- All outputs are registered.
- busy rises the cycle after start is sampled.
- start asserted while busy is ignored and not queued.
- CAPTURE samples puf_out exactly CAPTURE_DELAY cycles after the first cycle in which puf_state==3'b100 is observed.
- A state code of 100 lasting several cycles counts once.
- With a responsive engine, per-evaluation latency = (cycles to observe 001) + 1 (TRIG) + (engine run time) + CAPTURE_DELAY + 1.
- Total latency also adds 1 VOTE cycle, plus DONE dwell until resp_ready.
- resp_ready may be held high beforehand; the handshake then completes in the first DONE cycle.
- A new start is accepted in the cycle after returning to IDLE.
- The timeout counter saturates and compares with ≥ TIMEOUT. It is cleared on entering WAIT_IDLE and on entering TRIG.

## Test plan
- Behavioural engine model; NUM_EVAL=15; puf_out constant 96'hA5A5_..._A5 → resp_data = same value, resp_stable all ones, resp_error 0, exactly 15 single-cycle puf_trig pulses.
- Bit 0 reads 1 in 8 of 15 evaluations, bit 1 in 7 of 15 → resp_data[0]=1, resp_data[1]=0, resp_stable[1:0]=2'b00; other bits stable.
- Engine never reaches 3'b100 (stuck at 011) → after TIMEOUT=255 cycles: resp_valid=1, resp_error=1, resp_data=0; puf_trig pulsed once.
- resp_ready held low 50 cycles in DONE → outputs stable, no puf_trig; resp_ready=1 → IDLE next cycle, busy 0.
- Reset driven low during the 7th evaluation → next cycle: all outputs 0, no further puf_trig. A new start then yields a clean 15-evaluation result, with no carry-over from the aborted counts.
- start pulsed while busy, and puf_state held at 100 for 3 cycles → extra start ignored; capture occurs once, at CAPTURE_DELAY=2 after the first 100 cycle.
